// File: rtl/adc_acq_avg.sv
// Periodic ADC acquisition sequencer. It requests a conversion every PERIOD cycles
// and emits the truncated mean of each group of 2^AVG_LOG2 received samples.
module adc_acq_avg #(
    parameter int DW       = 16,
    parameter int AVG_LOG2 = 2,
    parameter int PERIOD   = 1000,
    parameter int TIMEOUT  = 4095
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          hab_i,
    input  logic [31:0]   data_i,
    output logic          strr_o,
    output logic [DW-1:0] avg_o,
    output logic          avg_vld_o,
    output logic          busy_o,
    output logic          tout_o,
    output logic          ovr_o
);

    localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = AVG_LOG2 + 1;
    localparam int AW = DW + AVG_LOG2;
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GROUP    = CW'(1 << AVG_LOG2);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        START,
        WAIT_DATA,
        ACC,
        DONE
    } state_e;

    state_e        state_q, state_d;
    state_e        resume;
    logic [PW-1:0] timer_q, timer_d;
    logic [TW-1:0] to_q, to_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] sum;
    logic [DW-1:0] sample_q, sample_d;
    logic [DW-1:0] avg_q, avg_d;
    logic          tout_q, tout_d;
    logic          ovr_q, ovr_d;
    logic          en_q;
    logic          tick;
    logic          en_rise;
    logic          timed_out;
    logic          unused_data;

    // Handshake: strr_o is a one-cycle request to the SPI receiver, which answers
    // with a one-cycle hab_i qualifying data_i; hab_i is accepted only in WAIT_DATA.
    assign tick        = (timer_q == PER_LAST);
    assign en_rise     = en_i & ~en_q;
    assign timed_out   = (to_q >= TO_LAST);
    assign sum         = acc_q + AW'(sample_q);
    assign unused_data = ^data_i;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        to_d     = to_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sample_d = sample_q;
        avg_d    = avg_q;
        tout_d   = en_rise ? 1'b0 : tout_q;
        ovr_d    = en_rise ? 1'b0 : ovr_q;

        // After a conversion ends, skip WAIT_TICK when the period has already elapsed.
        if (!en_i) begin
            resume = IDLE;
        end else if (tick) begin
            resume = START;
        end else begin
            resume = WAIT_TICK;
        end

        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (en_i) begin
                    state_d = START;
                end
            end
            WAIT_TICK: begin
                state_d = resume;
            end
            START: begin
                to_d    = TW'(1);
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                to_d = to_q + TW'(1);
                if (tick) begin
                    ovr_d = 1'b1;
                end
                if (hab_i) begin
                    sample_d = data_i[DW-1:0];
                    state_d  = ACC;
                end else if (timed_out) begin
                    tout_d  = 1'b1;
                    state_d = resume;
                end
            end
            ACC: begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
                if (!en_i) begin
                    state_d = IDLE;
                end else if (cnt_d == GROUP) begin
                    avg_d   = DW'(sum >> AVG_LOG2);
                    state_d = DONE;
                end else begin
                    state_d = resume;
                end
            end
            DONE: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = resume;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The timer reads 0 in the START cycle so consecutive starts are PERIOD apart.
        if (state_q == IDLE || state_d == START) begin
            timer_d = '0;
        end else if (!tick) begin
            timer_d = timer_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            to_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            avg_q    <= '0;
            tout_q   <= 1'b0;
            ovr_q    <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            to_q     <= to_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sample_q <= sample_d;
            avg_q    <= avg_d;
            tout_q   <= tout_d;
            ovr_q    <= ovr_d;
            en_q     <= en_i;
        end
    end

    assign strr_o    = (state_q == START);
    assign avg_vld_o = (state_q == DONE);
    assign busy_o    = (state_q != IDLE);
    assign avg_o     = avg_q;
    assign tout_o    = tout_q;
    assign ovr_o     = ovr_q;

endmodule
